wbs_spi_master: RTL and testbench
=================================

// Module: wbs_spi_master
// PURPOSE
//   Wishbone B4 pipelined slave that drives an external SPI bus as master
//   (mode 0, 8-bit frames, MSB first).
//   It is the controller-side counterpart of the SPI-slave bridge on the SPI
//   port, and plugs into one slave slot of the 1-master interconnect.
//   Software writes a byte to DATA to launch a frame and polls STATUS.
//   It reads the received byte from DATA and drives chip select through CTRL.
// PARAMETERS
//   WB_CLK_HZ   48_000_000  bus clock frequency in Hz
//   SPI_CLK_HZ  1_000_000   target SCK frequency; HALF = WB_CLK_HZ/(2*SPI_CLK_HZ), must be >= 1
// PORTS
//   wbs_clk_i    in   1   bus clock; all logic on rising edge
//   wbs_rst_ni   in   1   asynchronous active-low reset
//   wbs_cyc_i    in   1   bus cycle select for this slave
//   wbs_stb_i    in   1   request strobe
//   wbs_we_i     in   1   1 = write, 0 = read
//   wbs_adr_i    in   4   register index: 0 DATA, 1 STATUS, 2 CTRL, others reserved
//   wbs_sel_i    in   4   byte enables; only bit 0 is honoured
//   wbs_dat_i    in   32  write data
//   wbs_dat_o    out  32  read data, valid while wbs_ack_o is high
//   wbs_stall_o  out  1   request not accepted this cycle
//   wbs_ack_o    out  1   one-cycle acknowledge of an accepted request
//   spi_sck      out  1   SPI clock, idles low
//   spi_csn      out  1   chip select, active low
//   spi_sdo      out  1   MOSI
//   spi_sdi      in   1   MISO; passes through a 2-flop synchroniser before use
// BEHAVIOUR
//   Reset values (asynchronous, while wbs_rst_ni = 0):
//   - wbs_ack_o = 0, wbs_dat_o = 0, spi_sck = 0, spi_csn = 1, spi_sdo = 0.
//   - busy = 0, rx_valid = 0, rx = 0, FSM = IDLE.
//   - Reset during a frame aborts it immediately; no partial byte is kept.
//   Bus handshake:
//   - Accept = cyc & stb & !stall.
//   - wbs_stall_o = cyc & stb & we & (adr == 0) & busy. This is combinational.
//   - Every other request is accepted immediately.
//   - wbs_ack_o rises exactly 1 cycle after accept, for 1 cycle, with
//     wbs_dat_o registered alongside it.
//   - Back-to-back accepted requests give back-to-back acks.
//   - If cyc drops, pending acks are suppressed. A frame that has already
//     started runs to completion.
//   Registers (reads return zero in unused bits):
//   - DATA W: when sel[0] = 1, loads tx = dat_i[7:0] and starts a frame.
//   - DATA R: returns {24'b0, rx} and clears rx_valid.
//   - STATUS R: returns {30'b0, rx_valid, busy}. Writes are acked and ignored.
//   - CTRL W: when sel[0] = 1, spi_csn = !dat_i[0]. CTRL R: returns {31'b0, !spi_csn}.
//   - Reserved addresses: reads return 0; writes are acked with no effect.
//   - A write with sel[0] = 0 is acked with no effect.
//   FSM IDLE -> LOW -> HIGH -> LOW ... -> IDLE:
//   - IDLE: on a DATA write, busy = 1, spi_sdo = tx[7], bit count = 7,
//     go to LOW, divider = 0.
//   - LOW: spi_sck = 0. After HALF cycles, spi_sck = 1, sample the
//     synchronised sdi into the shift register LSB, go to HIGH.
//   - HIGH: after HALF cycles, spi_sck = 0.
//     If bit count == 0: rx = shifted byte, rx_valid = 1, busy = 0, go to IDLE.
//     Otherwise: shift tx, drive the next bit on spi_sdo, decrement the
//     count, go to LOW.
//   - Frame length is 16*HALF cycles from accept to busy falling.
//     spi_sck makes exactly 8 rising edges.
//   - spi_csn is fully software controlled. It is never toggled by the FSM,
//     and a CTRL write takes effect even mid-frame.
//   - A frame completing in the same cycle as a DATA read leaves rx_valid = 1;
//     the read returns the old rx.
//   - The sdi synchroniser adds a 2-cycle MISO sampling lag. Slave timing
//     margin requires HALF >= 3.
// TESTING
//   1. Reset: hold wbs_rst_ni = 0 mid-frame -> sck = 0, csn = 1, STATUS reads 0 after release.
//   2. HALF = 4; CTRL <- 1, DATA <- 0xA5, loopback sdo->sdi -> sdo shows 1,0,1,0,0,1,0,1;
//      busy clears 64 cycles after accept; STATUS = 0x2; DATA read = 0xA5; then STATUS = 0x0.
//   3. Write DATA 0x3C while busy -> stall held high until busy falls, then accepted;
//      second frame sends 0x3C; no ack during stall.
//   4. sdi tied to 1, DATA <- 0x00 -> rx = 0xFF; exactly 8 sck rising edges counted.
//   5. Pipelined reads STATUS, CTRL, adr 7 on consecutive cycles -> 3 consecutive acks,
//      data 0x1/0x1/0x0 when busy with csn asserted.
//   6. DATA write with sel = 4'b0010 -> acked, busy stays 0, no sck activity.

Source files
------------

// File: rtl/wbs_spi_master.sv
// wbs_spi_master
//   Wishbone B4 pipelined slave that runs an SPI bus as master
//   (mode 0, 8-bit frames, MSB first). Software writes DATA to launch a
//   frame, polls STATUS, reads the received byte from DATA and drives chip
//   select through CTRL.
//
//   Handshake: a request is taken on a rising edge when cyc & stb are high
//   and stall is low; stall only rises for a DATA write while a frame is in
//   flight. The ack follows one cycle later, for one cycle, with the read
//   data registered alongside it, and is withheld if cyc has dropped.
//
// Ports
//   wbs_clk_i, wbs_rst_ni : bus clock, asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i[3:0], wbs_sel_i[3:0],
//   wbs_dat_i[31:0]       : Wishbone request (adr 0 DATA, 1 STATUS, 2 CTRL)
//   wbs_dat_o[31:0], wbs_stall_o, wbs_ack_o : Wishbone response
//   spi_sck, spi_csn, spi_sdo, spi_sdi : SPI master pins
//   dbg_state[1:0]        : current FSM state (0 idle, 1 low, 2 high)
`timescale 1ns/1ps
module wbs_spi_master #(
    parameter int WB_CLK_HZ  = 48_000_000,
    parameter int SPI_CLK_HZ = 1_000_000
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic [1:0]  dbg_state
);
    localparam int HALF  = WB_CLK_HZ / (2 * SPI_CLK_HZ);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           state;
    logic             busy;
    logic             rx_valid;
    logic             ack_q;
    logic             sdi_meta;
    logic             sdi_sync;
    logic [7:0]       tx;
    logic [7:0]       rx;
    logic [7:0]       shift_rx;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div;

    logic is_data;
    logic accept;
    logic data_go;
    logic data_rd;
    logic ctrl_go;

    // Upper data bits and byte lanes 1..3 carry nothing for this slave.
    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

    assign is_data     = (wbs_adr_i == 4'd0);
    assign wbs_stall_o = wbs_cyc_i & wbs_stb_i & wbs_we_i & is_data & busy;
    assign accept      = wbs_cyc_i & wbs_stb_i & ~wbs_stall_o;
    assign data_go     = accept & wbs_we_i & is_data & wbs_sel_i[0];
    assign data_rd     = accept & ~wbs_we_i & is_data;
    assign ctrl_go     = accept & wbs_we_i & (wbs_adr_i == 4'd2) & wbs_sel_i[0];

    // A master that abandons its cycle must not see a stale ack.
    assign wbs_ack_o = ack_q & wbs_cyc_i;
    assign dbg_state = state;

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sdi_meta <= spi_sdi;
            sdi_sync <= sdi_meta;
        end
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            ack_q     <= 1'b0;
            wbs_dat_o <= '0;
            spi_sck   <= 1'b0;
            spi_csn   <= 1'b1;
            spi_sdo   <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            rx        <= '0;
            tx        <= '0;
            shift_rx  <= '0;
            bit_cnt   <= '0;
            div       <= '0;
            state     <= ST_IDLE;
        end else begin
            ack_q <= accept;

            if (accept) begin
                if (wbs_we_i) begin
                    wbs_dat_o <= '0;
                end else begin
                    case (wbs_adr_i)
                        4'd0:    wbs_dat_o <= {24'b0, rx};
                        4'd1:    wbs_dat_o <= {30'b0, rx_valid, busy};
                        4'd2:    wbs_dat_o <= {31'b0, ~spi_csn};
                        default: wbs_dat_o <= '0;
                    endcase
                end
            end

            if (ctrl_go) begin
                spi_csn <= ~wbs_dat_i[0];
            end

            // A frame finishing in this same cycle sets rx_valid below and
            // overrides this clear, so the fresh byte is not lost.
            if (data_rd) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (data_go) begin
                        tx      <= wbs_dat_i[7:0];
                        spi_sdo <= wbs_dat_i[7];
                        bit_cnt <= 3'd7;
                        div     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        spi_sck  <= 1'b1;
                        shift_rx <= {shift_rx[6:0], sdi_sync};
                        state    <= ST_HIGH;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (div == DIV_LAST) begin
                        div     <= '0;
                        spi_sck <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            rx       <= shift_rx;
                            rx_valid <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tx      <= {tx[6:0], 1'b0};
                            spi_sdo <= tx[6];
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= ST_LOW;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wbs_spi_master.sv
// tb_wbs_spi_master
//   Self-checking bench for wbs_spi_master with HALF = 4 (8 MHz bus clock,
//   1 MHz SCK). MISO is either looped back from MOSI or tied to a constant.
//   A reference model tracks rx, rx_valid and chip select from the register
//   rules; expected MOSI bits are queued MSB first per launched byte.
`timescale 1ns/1ps
module tb_wbs_spi_master;
    localparam int HALF  = 4;
    localparam int FRAME = 16 * HALF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        stall;
    logic        ack;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_sdo;
    logic        spi_sdi;
    logic [1:0]  dbg_state;

    logic loop_en = 1'b1;
    logic sdi_const = 1'b0;
    assign spi_sdi = loop_en ? spi_sdo : sdi_const;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;
    int rise_cnt = 0;
    int last_fall = 0;

    logic sdo_q[$];
    logic [0:0] exp_q[$];

    // Reference model state
    logic       m_rx_valid = 1'b0;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_pending = 8'h00;
    logic       m_cs = 1'b0;

    wbs_spi_master #(
        .WB_CLK_HZ (8_000_000),
        .SPI_CLK_HZ(1_000_000)
    ) dut (
        .wbs_clk_i  (clk),
        .wbs_rst_ni (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_w),
        .wbs_dat_o  (dat_r),
        .wbs_stall_o(stall),
        .wbs_ack_o  (ack),
        .spi_sck    (spi_sck),
        .spi_csn    (spi_csn),
        .spi_sdo    (spi_sdo),
        .spi_sdi    (spi_sdi),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(negedge clk) cyc_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- SPI monitor ----------------
    always @(posedge spi_sck) begin
        rise_cnt++;
        sdo_q.push_back(spi_sdo);
    end
    always @(negedge spi_sck) last_fall = cyc_cnt;

    // ---------------- model helpers ----------------
    function automatic logic [7:0] model_rx(input logic [7:0] t);
        return loop_en ? t : {8{sdi_const}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_xfer(input logic we_v, input logic [3:0] adr_v,
                            input logic [31:0] dat_v, input logic [3:0] sel_v,
                            output logic [31:0] rdat, output logic ack_ok,
                            output int stalls, output logic ack_in_stall,
                            output int acc);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; dat_w = dat_v; sel = sel_v;
        stalls = 0;
        ack_in_stall = 1'b0;
        rdat = '0;
        ack_ok = 1'b0;
        acc = -1;
        @(negedge clk);
        while (stall && stalls < 400) begin
            stalls++;
            if (ack) ack_in_stall = 1'b1;
            @(negedge clk);
        end
        if (stall) begin
            @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc_cnt;
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        ack_ok = ack;
        rdat = dat_r;
        @(posedge clk);
        #1;
        cyc = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic ack_ok, output int acc);
        logic [31:0] rd;
        int st;
        logic ais;
        bus_xfer(1'b1, a, d, s, rd, ack_ok, st, ais, acc);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] rd, output logic ack_ok);
        int st;
        int acc;
        logic ais;
        bus_xfer(1'b0, a, '0, 4'hF, rd, ack_ok, st, ais, acc);
    endtask

    task automatic launch(input logic [7:0] t, output logic ack_ok, output int acc);
        bus_write(4'd0, {24'h0, t}, 4'h1, ack_ok, acc);
        for (int i = 7; i >= 0; i--) exp_q.push_back(t[i]);
        m_pending = model_rx(t);
    endtask

    task automatic wait_idle(output logic ok);
        logic [31:0] rd;
        logic a;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus_read(4'd1, rd, a);
            if (rd[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            m_rx = m_pending;
            m_rx_valid = 1'b1;
        end
    endtask

    task automatic drain_bits(output logic [15:0] got, output logic [15:0] want,
                              output int n_got, output int n_want);
        got = '0;
        want = '0;
        n_got = sdo_q.size();
        n_want = exp_q.size();
        while (sdo_q.size() > 0) got = {got[14:0], sdo_q.pop_front()};
        while (exp_q.size() > 0) want = {want[14:0], exp_q.pop_front()};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] rd;
        logic a;
        int acc;
        int r0;
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ack); end
        vectors++; if (dat_r !== 32'h0) begin miscompares++; $display("FAIL reset_dat: got %h expected 0", dat_r); end
        vectors++; if (spi_sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
        vectors++; if (spi_csn !== 1'b1) begin miscompares++; $display("FAIL reset_csn: got %b expected 1", spi_csn); end
        vectors++; if (spi_sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b expected 0", spi_sdo); end

        bus_write(4'd2, 32'h1, 4'h1, a, acc);
        launch(8'h5A, a, acc);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (spi_sck !== 1'b0) begin miscompares++; $display("FAIL midframe_reset_sck: got %b expected 0", spi_sck); end
        vectors++; if (spi_csn !== 1'b1) begin miscompares++; $display("FAIL midframe_reset_csn: got %b expected 1", spi_csn); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_rx_valid = 1'b0; m_rx = 8'h00; m_cs = 1'b0;
        exp_q.delete(); sdo_q.delete();
        r0 = rise_cnt;
        bus_read(4'd1, rd, a);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", rd); end
        bus_read(4'd0, rd, a);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_rx: got %h expected 0", rd); end
        repeat (40) @(posedge clk);
        vectors++; if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL reset_no_sck: got %0d edges expected 0", rise_cnt - r0); end
    endtask

    task automatic test_loopback;
        logic [31:0] rd;
        logic a;
        logic ok;
        int acc;
        logic [15:0] got, want;
        int ng, nw;
        loop_en = 1'b1;
        bus_write(4'd2, 32'h1, 4'h1, a, acc);
        m_cs = 1'b1;
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL ctrl_ack: got %b expected 1", a); end
        vectors++; if (spi_csn !== ~m_cs) begin miscompares++; $display("FAIL ctrl_csn: got %b expected %b", spi_csn, ~m_cs); end
        sdo_q.delete(); exp_q.delete();
        launch(8'hA5, a, acc);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL data_ack: got %b expected 1", a); end
        wait_idle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL loop_timeout: got %b expected 1", ok); end
        vectors++; if (last_fall - acc !== FRAME) begin miscompares++; $display("FAIL frame_len: got %0d expected %0d", last_fall - acc, FRAME); end
        drain_bits(got, want, ng, nw);
        vectors++; if (ng !== nw || got !== want) begin miscompares++; $display("FAIL loop_sdo: got %0d bits %h expected %0d bits %h", ng, got, nw, want); end
        bus_read(4'd1, rd, a);
        vectors++; if (rd !== {30'b0, m_rx_valid, 1'b0}) begin miscompares++; $display("FAIL loop_status_done: got %h expected %h", rd, {30'b0, m_rx_valid, 1'b0}); end
        bus_read(4'd0, rd, a);
        vectors++; if (rd !== {24'b0, m_rx}) begin miscompares++; $display("FAIL loop_rx: got %h expected %h", rd, {24'b0, m_rx}); end
        m_rx_valid = 1'b0;
        bus_read(4'd1, rd, a);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL loop_status_clear: got %h expected 0", rd); end
    endtask

    task automatic test_stall;
        logic [31:0] rd;
        logic a, ais, ok;
        int acc1, acc2, st;
        logic [15:0] got, want;
        int ng, nw;
        loop_en = 1'b1;
        sdo_q.delete(); exp_q.delete();
        launch(8'h11, a, acc1);
        bus_xfer(1'b1, 4'd0, 32'h3C, 4'h1, rd, a, st, ais, acc2);
        for (int i = 7; i >= 0; i--) exp_q.push_back(1'(8'h3C >> i));
        m_pending = model_rx(8'h3C);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL stall_ack: got %b expected 1", a); end
        vectors++; if (ais !== 1'b0) begin miscompares++; $display("FAIL ack_during_stall: got %b expected 0", ais); end
        vectors++; if (st == 0) begin miscompares++; $display("FAIL stall_seen: got %0d stall cycles expected >0", st); end
        vectors++; if (acc2 - acc1 !== FRAME + 1) begin miscompares++; $display("FAIL stall_release: got %0d expected %0d", acc2 - acc1, FRAME + 1); end
        wait_idle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_timeout: got %b expected 1", ok); end
        drain_bits(got, want, ng, nw);
        vectors++; if (ng !== nw || got !== want) begin miscompares++; $display("FAIL b2b_sdo: got %0d bits %h expected %0d bits %h", ng, got, nw, want); end
        bus_read(4'd0, rd, a);
        vectors++; if (rd !== {24'b0, m_rx}) begin miscompares++; $display("FAIL b2b_rx: got %h expected %h", rd, {24'b0, m_rx}); end
        m_rx_valid = 1'b0;
    endtask

    task automatic test_sdi_ones;
        logic [31:0] rd;
        logic a, ok;
        int acc, r0;
        logic [15:0] got, want;
        int ng, nw;
        loop_en = 1'b0;
        sdi_const = 1'b1;
        sdo_q.delete(); exp_q.delete();
        r0 = rise_cnt;
        launch(8'h00, a, acc);
        wait_idle(ok);
        vectors++; if (rise_cnt - r0 !== 8) begin miscompares++; $display("FAIL sck_edges: got %0d expected 8", rise_cnt - r0); end
        drain_bits(got, want, ng, nw);
        vectors++; if (ng !== nw || got !== want) begin miscompares++; $display("FAIL ones_sdo: got %0d bits %h expected %0d bits %h", ng, got, nw, want); end
        bus_read(4'd0, rd, a);
        vectors++; if (rd !== {24'b0, m_rx}) begin miscompares++; $display("FAIL ones_rx: got %h expected %h", rd, {24'b0, m_rx}); end
        m_rx_valid = 1'b0;
        loop_en = 1'b1;
    endtask

    task automatic test_pipelined_reads;
        logic [31:0] rd;
        logic a, ok;
        int acc;
        logic [7:0] t;
        logic [3:0]  adrs [3];
        logic [31:0] exps [3];
        t = 8'($urandom_range(0, 255));
        launch(t, a, acc);
        adrs[0] = 4'd1; adrs[1] = 4'd2; adrs[2] = 4'd7;
        exps[0] = {30'b0, m_rx_valid, 1'b1};
        exps[1] = {31'b0, m_cs};
        exps[2] = 32'h0;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = adrs[0]; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) adr = adrs[i + 1];
            else stb = 1'b0;
            @(negedge clk);
            vectors++; if (ack !== 1'b1 || dat_r !== exps[i]) begin miscompares++; $display("FAIL pipe_read%0d: got ack %b data %h expected ack 1 data %h", i, ack, dat_r, exps[i]); end
        end
        @(posedge clk);
        #1 cyc = 1'b0;
        wait_idle(ok);
        bus_read(4'd0, rd, a);
        vectors++; if (rd !== {24'b0, m_rx}) begin miscompares++; $display("FAIL pipe_rx: got %h expected %h", rd, {24'b0, m_rx}); end
        m_rx_valid = 1'b0;
    endtask

    task automatic test_sel_ignored;
        logic [31:0] rd;
        logic a;
        int acc, r0;
        r0 = rise_cnt;
        bus_write(4'd0, 32'hFF, 4'b0010, a, acc);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL sel_ack: got %b expected 1", a); end
        repeat (30) @(posedge clk);
        vectors++; if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL sel_no_sck: got %0d expected 0", rise_cnt - r0); end
        bus_read(4'd1, rd, a);
        vectors++; if (rd !== {30'b0, m_rx_valid, 1'b0}) begin miscompares++; $display("FAIL sel_status: got %h expected %h", rd, {30'b0, m_rx_valid, 1'b0}); end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic a, ok, c;
        int acc;
        logic [7:0] t;
        logic [3:0] ra;
        logic [15:0] got, want;
        int ng, nw;
        for (int n = 0; n < 8; n++) begin
            t = 8'($urandom_range(0, 255));
            loop_en = 1'($urandom_range(0, 1));
            sdi_const = 1'($urandom_range(0, 1));
            sdo_q.delete(); exp_q.delete();
            launch(t, a, acc);
            bus_read(4'd1, rd, a);
            vectors++; if (rd !== {30'b0, m_rx_valid, 1'b1}) begin miscompares++; $display("FAIL rnd_status_busy%0d: got %h expected %h", n, rd, {30'b0, m_rx_valid, 1'b1}); end
            c = 1'($urandom_range(0, 1));
            bus_write(4'd2, {$urandom(), c} >> 0 & 32'h1, 4'h1, a, acc);
            m_cs = c;
            vectors++; if (spi_csn !== ~m_cs) begin miscompares++; $display("FAIL rnd_csn%0d: got %b expected %b", n, spi_csn, ~m_cs); end
            ra = 4'($urandom_range(3, 15));
            bus_write(ra, $urandom(), 4'hF, a, acc);
            bus_read(ra, rd, a);
            vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rnd_reserved%0d: got %h expected 0", n, rd); end
            wait_idle(ok);
            drain_bits(got, want, ng, nw);
            vectors++; if (ng !== nw || got !== want) begin miscompares++; $display("FAIL rnd_sdo%0d: got %0d bits %h expected %0d bits %h", n, ng, got, nw, want); end
            bus_read(4'd0, rd, a);
            vectors++; if (rd !== {24'b0, m_rx}) begin miscompares++; $display("FAIL rnd_rx%0d: got %h expected %h", n, rd, {24'b0, m_rx}); end
            m_rx_valid = 1'b0;
        end
        loop_en = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_stall();
        test_sdi_ones();
        test_pipelined_reads();
        test_sel_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
